// File: rtl/float_mult_pipe.sv
// float_mult_pipe: three-stage floating-point multiplier with valid/ready on
// both sides. Stage 1 classifies operands and sums exponents, stage 2
// multiplies significands, stage 3 normalises, rounds to nearest-even,
// applies range checks and presents the registered result and flags.
module float_mult_pipe #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   float_a,
  input  logic [EXP_W+MAN_W:0]   float_b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   product,
  output logic                   flag_of,
  output logic                   flag_uf,
  output logic                   flag_nv
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int XW = EXP_W + 2;          // signed exponent width, cannot wrap
  localparam int SW = MAN_W + 1;          // significand with hidden one
  localparam int PW = 2 * SW;             // significand product width

  localparam logic [EXP_W-1:0] EMAX   = '1;
  localparam logic [XW-1:0]    BIAS_X = XW'((1 << (EXP_W - 1)) - 1);

  typedef enum logic [1:0] {
    CLS_NUM,
    CLS_ZERO,
    CLS_INF,
    CLS_NAN
  } cls_e;

  // Pipeline occupancy and load enables
  logic r_v1, r_v2, r_v3;
  logic w_ld1, w_ld2, w_ld3;

  // A stage may load when it is empty or its content moves on this edge.
  assign w_ld3     = !r_v3 || out_ready;
  assign w_ld2     = !r_v2 || w_ld3;
  assign w_ld1     = !r_v1 || w_ld2;
  assign in_ready  = w_ld1;
  assign out_valid = r_v3;

  // Stage 1 combinational: field extraction and classification
  logic [EXP_W-1:0] w_ea, w_eb;
  logic [MAN_W-1:0] w_ma, w_mb;
  logic             w_zero_a, w_zero_b, w_inf_a, w_inf_b, w_nan_a, w_nan_b;
  logic [XW-1:0]    w_esum;
  cls_e             w_cls1;

  assign w_ea     = float_a[W-2 -: EXP_W];
  assign w_eb     = float_b[W-2 -: EXP_W];
  assign w_ma     = float_a[MAN_W-1:0];
  assign w_mb     = float_b[MAN_W-1:0];
  assign w_zero_a = (w_ea == '0);
  assign w_zero_b = (w_eb == '0);
  assign w_inf_a  = (w_ea == EMAX) && (w_ma == '0);
  assign w_inf_b  = (w_eb == EMAX) && (w_mb == '0);
  assign w_nan_a  = (w_ea == EMAX) && (w_ma != '0);
  assign w_nan_b  = (w_eb == EMAX) && (w_mb != '0);
  // Two's-complement sum; negative values mean certain underflow.
  assign w_esum   = {2'b00, w_ea} + {2'b00, w_eb} - BIAS_X;

  // Special-value priority: NaN / inf*zero, then infinity, then zero.
  always_comb begin
    // NOTE: default first so every path assigns w_cls1 and no latch is inferred.
    w_cls1 = CLS_NUM;
    if (w_nan_a || w_nan_b || (w_inf_a && w_zero_b) || (w_inf_b && w_zero_a))
      w_cls1 = CLS_NAN;
    else if (w_inf_a || w_inf_b)
      w_cls1 = CLS_INF;
    else if (w_zero_a || w_zero_b)
      w_cls1 = CLS_ZERO;
  end

  // Stage valid bits advance together with their data
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst) begin
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
      r_v3 <= 1'b0;
    end else begin
      if (w_ld1) r_v1 <= in_valid;
      if (w_ld2) r_v2 <= r_v1;
      if (w_ld3) r_v3 <= r_v2;
    end
  end

  // Stage 1 and 2 datapath registers
  logic          r1_sign, r2_sign;
  cls_e          r1_cls, r2_cls;
  logic [XW-1:0] r1_exp, r2_exp;
  logic [SW-1:0] r1_ma, r1_mb;
  logic [PW-1:0] r2_prod;

  // Capture operands on input transfer, multiply when stage 1 moves on
  always_ff @(posedge clk) begin
    // NOTE: datapath registers are not reset; the valid bits qualify them.
    if (in_valid && w_ld1) begin
      r1_sign <= float_a[W-1] ^ float_b[W-1];
      r1_cls  <= w_cls1;
      r1_exp  <= w_esum;
      r1_ma   <= {1'b1, w_ma};
      r1_mb   <= {1'b1, w_mb};
    end
    if (r_v1 && w_ld2) begin
      r2_sign <= r1_sign;
      r2_cls  <= r1_cls;
      r2_exp  <= r1_exp;
      r2_prod <= PW'(r1_ma) * PW'(r1_mb);
    end
  end

  // Stage 3 combinational: normalise, round, range check
  logic              w_msb, w_guard, w_sticky, w_rnd, w_of, w_uf, w_nv;
  logic [PW-2:0]     w_sh;
  logic [MAN_W-1:0]  w_mant;
  logic [MAN_W:0]    w_mant_r;
  logic [XW-1:0]     w_exp3;
  logic              w_exp_hi, w_exp_lo;
  logic [W-1:0]      w_res;

  // After the shift the leading one sits just above bit PW-2.
  assign w_msb    = r2_prod[PW-1];
  assign w_sh     = w_msb ? r2_prod[PW-2:0] : {r2_prod[PW-3:0], 1'b0};
  assign w_mant   = w_sh[PW-2 -: MAN_W];
  assign w_guard  = w_sh[MAN_W];
  assign w_sticky = |w_sh[MAN_W-1:0];
  assign w_rnd    = w_guard && (w_sticky || w_mant[0]);
  // A carry out leaves the low MAN_W bits at zero, as required.
  assign w_mant_r = {1'b0, w_mant} + SW'(w_rnd);
  assign w_exp3   = r2_exp + XW'(w_msb) + XW'(w_mant_r[MAN_W]);
  assign w_exp_hi = !w_exp3[XW-1] && (w_exp3[XW-2:0] >= {1'b0, EMAX});
  assign w_exp_lo = w_exp3[XW-1] || (w_exp3 == '0);

  // Select final result word and exactly one (or no) flag
  always_comb begin
    w_res = '0;
    w_of  = 1'b0;
    w_uf  = 1'b0;
    w_nv  = 1'b0;
    unique case (r2_cls)
      CLS_NAN: begin
        w_res = {1'b0, EMAX, 1'b1, {(MAN_W-1){1'b0}}};
        w_nv  = 1'b1;
      end
      CLS_INF:  w_res = {r2_sign, EMAX, {MAN_W{1'b0}}};
      CLS_ZERO: w_res = {r2_sign, {(W-1){1'b0}}};
      default: begin
        if (w_exp_hi) begin
          w_res = {r2_sign, EMAX, {MAN_W{1'b0}}};
          w_of  = 1'b1;
        end else if (w_exp_lo) begin
          w_res = {r2_sign, {(W-1){1'b0}}};
          w_uf  = 1'b1;
        end else begin
          w_res = {r2_sign, w_exp3[EXP_W-1:0], w_mant_r[MAN_W-1:0]};
        end
      end
    endcase
  end

  // Output register; holds while stalled, cleared on reset
  always_ff @(posedge clk) begin
    if (rst) begin
      product <= '0;
      flag_of <= 1'b0;
      flag_uf <= 1'b0;
      flag_nv <= 1'b0;
    end else if (r_v2 && w_ld3) begin
      product <= w_res;
      flag_of <= w_of;
      flag_uf <= w_uf;
      flag_nv <= w_nv;
    end
  end

endmodule

// File: tb/tb_float_mult_pipe.sv
// Directed bench for float_mult_pipe: half-precision vectors through the
// default instance plus one single-precision vector through a second one.
// Observed result word is {out_valid, product, flag_of, flag_uf, flag_nv}.
module tb_float_mult_pipe;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Half-precision instance
  logic        h_in_valid, h_in_ready, h_out_valid, h_out_ready;
  logic [15:0] h_a, h_b, h_product;
  logic        h_of, h_uf, h_nv;

  float_mult_pipe u_half (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (h_in_valid),
    .in_ready  (h_in_ready),
    .float_a   (h_a),
    .float_b   (h_b),
    .out_valid (h_out_valid),
    .out_ready (h_out_ready),
    .product   (h_product),
    .flag_of   (h_of),
    .flag_uf   (h_uf),
    .flag_nv   (h_nv)
  );

  // Single-precision instance
  logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready;
  logic [31:0] s_a, s_b, s_product;
  logic        s_of, s_uf, s_nv;

  float_mult_pipe #(.EXP_W(8), .MAN_W(23)) u_single (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (s_in_valid),
    .in_ready  (s_in_ready),
    .float_a   (s_a),
    .float_b   (s_b),
    .out_valid (s_out_valid),
    .out_ready (s_out_ready),
    .product   (s_product),
    .flag_of   (s_of),
    .flag_uf   (s_uf),
    .flag_nv   (s_nv)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] p;
    logic [2:0]  f;   // {of, uf, nv}
  } vec_t;

  vec_t vecs[12];
  vec_t bp[4];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] h_obs();
    return 64'({h_out_valid, h_product, h_of, h_uf, h_nv});
  endfunction

  function automatic logic [63:0] h_exp(input vec_t v);
    return 64'({1'b1, v.p, v.f});
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_h(input vec_t v);
    h_in_valid = 1'b1;
    h_a        = v.a;
    h_b        = v.b;
  endtask

  initial begin
    vecs[0]  = '{16'h3E00, 16'h3E00, 16'h4080, 3'b000};
    vecs[1]  = '{16'hBC00, 16'h4000, 16'hC000, 3'b000};
    vecs[2]  = '{16'h3C00, 16'h0000, 16'h0000, 3'b000};
    vecs[3]  = '{16'h3C01, 16'h3C01, 16'h3C02, 3'b000};
    vecs[4]  = '{16'h3C01, 16'h3E00, 16'h3E02, 3'b000};
    vecs[5]  = '{16'h3C03, 16'h3E00, 16'h3E04, 3'b000};
    vecs[6]  = '{16'h7BFF, 16'h4000, 16'h7C00, 3'b100};
    vecs[7]  = '{16'h0400, 16'h3800, 16'h0000, 3'b010};
    vecs[8]  = '{16'h8400, 16'h3800, 16'h8000, 3'b010};
    vecs[9]  = '{16'h7C00, 16'h0000, 16'h7E00, 3'b001};
    vecs[10] = '{16'h7E01, 16'h3C00, 16'h7E00, 3'b001};
    vecs[11] = '{16'hFC00, 16'h4000, 16'hFC00, 3'b000};
    bp[0] = vecs[0];
    bp[1] = vecs[1];
    bp[2] = vecs[4];
    bp[3] = vecs[6];

    rst         = 1'b1;
    h_in_valid  = 1'b0;
    h_a         = '0;
    h_b         = '0;
    h_out_ready = 1'b1;
    s_in_valid  = 1'b0;
    s_a         = '0;
    s_b         = '0;
    s_out_ready = 1'b1;

    // Reset state
    step();
    step();
    check("reset_outputs", h_obs(), 64'h0);
    rst = 1'b0;
    #1;
    check("reset_in_ready", 64'(h_in_ready), 64'h1);

    // Back-to-back stream: vector c is presented in cycle c and must be
    // on the output in cycle c+3 (i.e. after the loop step for index c+2).
    for (int c = 0; c < 14; c++) begin
      if (c < 12) drive_h(vecs[c]);
      else        h_in_valid = 1'b0;
      #1;
      if (c < 12) check($sformatf("stream_in_ready_%0d", c), 64'(h_in_ready), 64'h1);
      step();
      if (c >= 2) check($sformatf("stream_result_%0d", c - 2), h_obs(), h_exp(vecs[c-2]));
    end
    step();
    check("stream_drained", 64'(h_out_valid), 64'h0);

    // Back-pressure: fill three stages with the consumer stalled
    h_out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_h(bp[i]);
      #1;
      check($sformatf("bp_accept_%0d", i), 64'(h_in_ready), 64'h1);
      step();
    end
    drive_h(bp[3]);
    #1;
    check("bp_full_refuse", 64'(h_in_ready), 64'h0);
    check("bp_hold_a", h_obs(), h_exp(bp[0]));
    step();
    check("bp_full_refuse2", 64'(h_in_ready), 64'h0);
    check("bp_hold_b", h_obs(), h_exp(bp[0]));
    // One-cycle release: one result leaves, fourth pair enters
    h_out_ready = 1'b1;
    #1;
    check("bp_release_ready", 64'(h_in_ready), 64'h1);
    step();
    h_out_ready = 1'b0;
    h_in_valid  = 1'b0;
    #1;
    check("bp_next", h_obs(), h_exp(bp[1]));
    step();
    check("bp_next_hold", h_obs(), h_exp(bp[1]));
    h_out_ready = 1'b1;
    step();
    check("bp_third", h_obs(), h_exp(bp[2]));
    step();
    check("bp_fourth", h_obs(), h_exp(bp[3]));
    step();
    check("bp_empty", 64'(h_out_valid), 64'h0);

    // Reset with two operations in flight
    drive_h(vecs[0]);
    step();
    drive_h(vecs[1]);
    step();
    h_in_valid = 1'b0;
    rst        = 1'b1;
    step();
    rst = 1'b0;
    check("rst_flight_outputs", h_obs(), 64'h0);
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("rst_no_stale_%0d", i), 64'(h_out_valid), 64'h0);
    end

    // Single precision: 1.5 * 1.5 = 2.25
    s_in_valid = 1'b1;
    s_a        = 32'h3FC0_0000;
    s_b        = 32'h3FC0_0000;
    #1;
    check("sp_in_ready", 64'(s_in_ready), 64'h1);
    step();
    s_in_valid = 1'b0;
    step();
    check("sp_not_early", 64'(s_out_valid), 64'h0);
    step();
    check("sp_result", 64'({s_out_valid, s_product, s_of, s_uf, s_nv}),
          64'({1'b1, 32'h4010_0000, 3'b000}));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/float_mult_pipe.md
# float_mult_pipe

Parametrised, pipelined floating-point multiplier with valid/ready handshakes on both sides. Generalises the combinational half-precision multiplier to any exponent/mantissa width and adds round-to-nearest-even, IEEE-style special-value handling, overflow saturation and status flags. It sits between operand-issue logic and the result bus of the arithmetic unit. It accepts one operand pair per cycle and tolerates arbitrary back-pressure without losing or duplicating results.

## Interface
- EXP_W, 5, exponent field width (≥3)
- MAN_W, 10, stored mantissa field width (≥2); word width W = 1+EXP_W+MAN_W
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand pair presented
- in_ready  out  1  block can accept this cycle
- float_a, float_b  in  W each  operands {sign, exponent, mantissa}
- out_valid  out  1  result presented
- out_ready  in  1  consumer accepts this cycle
- product  out  W  result
- flag_of, flag_uf, flag_nv  out  1 each  overflow / underflow-flush / invalid, qualified by out_valid

## Operation
- BIAS = 2^(EXP_W-1)-1; EMAX = 2^EXP_W-1 (all-ones exponent).
- Input classes: exponent 0 is zero, with the mantissa ignored (subnormal inputs are flushed). Exponent EMAX with mantissa 0 is infinity. Exponent EMAX with mantissa ≠0 is NaN.
- Result sign = sign_a ^ sign_b for every result except NaN.
- Special cases take priority over arithmetic:
  - NaN operand, or inf × zero: product = canonical NaN {0, EMAX, 1 followed by zeros}, flag_nv=1.
  - inf × nonzero: {sign, EMAX, 0}, with no flags.
  - zero × finite: {sign, 0, 0}, with no flags.
- Stage 1: classify the operands. Compute the signed exponent sum ea+eb-BIAS at EXP_W+2 bits, which cannot wrap.
- Stage 2: multiply the significands {1,ma}×{1,mb}, (MAN_W+1)² giving a 2·MAN_W+2 bit product in [1,4).
- Stage 3, normalise: if the product MSB is set, shift right 1 and add 1 to the exponent.
- Stage 3, round to nearest, ties to even: use the guard bit plus the OR of all lower bits as sticky. A mantissa carry-out after rounding adds 1 to the exponent and the mantissa becomes 0.
- Stage 3, range checks after rounding:
  - exponent ≥ EMAX: product = {sign, EMAX, 0}, flag_of=1.
  - exponent ≤ 0: product = {sign, 0, 0}, flag_uf=1.
- Flags are mutually exclusive per result.

## Timing
- Three registered stages, each with its own valid bit v1, v2, v3; stage 3 drives out_valid, product and the flags.
- Stage k advances when stage k+1 is empty or advancing. Stage 3 advances when !v3 || out_ready.
- in_ready = !v1 || stage-1 advance. This path is combinational and depends on out_ready.
- A transfer occurs on a rising edge with valid && ready on that interface. There is no transfer otherwise.
- Latency is 3 cycles from input transfer to out_valid when out_ready stays high. Throughput is 1 result per cycle.
- When stalled, product and the flags hold stable while out_valid=1 && !out_ready. Results leave in acceptance order.
- Capacity is 3 results. With out_ready held low, the 4th pair is refused (in_ready=0).
- A simultaneous output transfer and input transfer on a full pipe is legal and moves every stage.
- Reset forces v1=v2=v3=0, out_valid=0, product=0 and all flags=0. After reset in_ready=1. In-flight operations are discarded and no partial result appears.
- Inputs on a cycle where in_ready=0 are ignored; the source must hold them.

## Test plan
- Basic, with defaults and out_ready=1. Each case must appear 3 cycles after acceptance, back-to-back at 1/cycle:
  - 0x3E00×0x3E00 → 0x4080
  - 0xBC00×0x4000 → 0xC000
  - 0x3C00×0x0000 → 0x0000
- Rounding:
  - 0x3C01×0x3C01 → 0x3C02 (round down)
  - 0x3C01×0x3E00 → 0x3E02 (tie, rounds up to even)
  - 0x3C03×0x3E00 → 0x3E04 (tie, rounds down to even)
- Range:
  - 0x7BFF×0x4000 → 0x7C00 with flag_of=1
  - 0x0400×0x3800 → 0x0000 with flag_uf=1
  - 0x8400×0x3800 → 0x8000 with flag_uf=1
- Specials:
  - 0x7C00×0x0000 → 0x7E00 with flag_nv=1
  - 0x7E01×0x3C00 → 0x7E00 with flag_nv=1
  - 0xFC00×0x4000 → 0xFC00 with no flags
- Back-pressure: with out_ready=0, issue 4 pairs; in_ready drops after the 3rd. Release out_ready for 1 cycle: exactly one result leaves and the 4th pair is accepted in that same cycle. All 4 results arrive in order, with product stable during stalls.
- Reset and parametrisation:
  - Assert rst with 2 operations in flight: out_valid=0 on the next cycle and no stale result ever appears.
  - Instantiate EXP_W=8, MAN_W=23: 0x3FC00000×0x3FC00000 → 0x40100000.
